// File: rtl/ps2_rx_frame_if.sv
// FIFO-side bundle of the PS/2 frame receiver.
// master = receiver, slave = FIFO / consumer.
interface ps2_rx_frame_if;
  logic [7:0] rx_data;
  logic       wr_en;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;
  logic       buf_full;

  modport master (
    output rx_data,
    output wr_en,
    output frame_err,
    output overrun,
    output rx_busy,
    input  buf_full
  );

  modport slave (
    input  rx_data,
    input  wr_en,
    input  frame_err,
    input  overrun,
    input  rx_busy,
    output buf_full
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver feeding an 8-bit FIFO.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_rx_frame_if.master bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

  logic [1:0]    clk_s;
  logic [1:0]    dat_s;
  logic          clk_f;
  logic          clk_q;
  logic [FW-1:0] fcnt;
  logic          fall;
  logic          din;

  state_t        state;
  logic [10:0]   sr;
  logic [3:0]    bcnt;
  logic [TW-1:0] tcnt;
  logic [7:0]    rx_data;
  logic          wr_en;
  logic          frame_err;
  logic          overrun;
  logic          good;

  assign din  = dat_s[1];
  assign fall = clk_q & ~clk_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_f <= 1'b1;
      clk_q <= 1'b1;
      fcnt  <= '0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      clk_q <= clk_f;
      if (clk_s[1] != clk_f) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          clk_f <= clk_s[1];
          fcnt  <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  // sr[0]=start, sr[8:1]=data, sr[9]=parity, sr[10]=stop
  assign good = ~sr[0] & sr[10] &
                ((^sr[9:1]) | ~PAR_EN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      bcnt      <= '0;
      tcnt      <= '0;
      rx_data   <= '0;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      unique case (state)
        IDLE: begin
          tcnt <= '0;
          if (fall && !din) begin
            sr    <= {din, sr[10:1]};
            bcnt  <= 4'd1;
            state <= RECV;
          end
        end
        RECV: begin
          if (fall) begin
            sr   <= {din, sr[10:1]};
            bcnt <= bcnt + 4'd1;
            tcnt <= '0;
            if (bcnt == 4'd10) state <= CHECK;
          end else if (tcnt == TW'(TIMEOUT_CYCLES)) begin
            frame_err <= 1'b1;
            tcnt      <= '0;
            bcnt      <= '0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        CHECK: begin
          bcnt  <= '0;
          state <= IDLE;
          if (!good) begin
            frame_err <= 1'b1;
          end else if (bus.buf_full) begin
            overrun <= 1'b1;
          end else begin
            rx_data <= sr[8:1];
            wr_en   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data   = rx_data;
  assign bus.wr_en     = wr_en;
  assign bus.frame_err = frame_err;
  assign bus.overrun   = overrun;
  assign bus.rx_busy   = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed scoreboard bench for ps2_rx_frame.
// Expected FIFO-side events are queued as frames are driven.
module tb_ps2_rx_frame;

  localparam int HALF = 20;
  localparam logic [2:0] K_WR  = 3'b100;
  localparam logic [2:0] K_OVR = 3'b010;
  localparam logic [2:0] K_ERR = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic ps2_clk;
  logic ps2_data;

  ps2_rx_frame_if bus ();

  ps2_rx_frame #(
    .FILTER_LEN(8),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .bus(bus)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  logic [7:0] last = 8'h00;

  always @(negedge clk) begin
    if (bus.wr_en | bus.overrun | bus.frame_err)
      obs_q.push_back('{kind: {bus.wr_en, bus.overrun, bus.frame_err},
                        data: bus.rx_data});
  end

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [7:0] d);
    exp_q.push_back('{kind: k, data: d});
  endtask

  task automatic expect_ev(input string tag);
    ev_t e;
    ev_t o;
    int  n;
    n = 0;
    e = exp_q.pop_front();
    while (obs_q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, 32'(obs_q.size() != 0), 32'd1);
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      chk({tag, "_kind"}, 32'(o.kind), 32'(e.kind));
      chk({tag, "_data"}, 32'(o.data), 32'(e.data));
    end
  endtask

  task automatic send(input logic [7:0] d, input logic p,
                      input logic s, input int nb);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < nb; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic quiet(input string tag);
    repeat (30) @(negedge clk);
    chk({tag, "_busy"}, 32'(bus.rx_busy), 32'd0);
    chk({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    ps2_clk      = 1'b1;
    ps2_data     = 1'b1;
    bus.buf_full = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", 32'(bus.rx_data), 32'h00);
    chk("rst_wr", 32'(bus.wr_en), 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    chk("rst_busy", 32'(bus.rx_busy), 32'd0);

    push(K_WR, 8'h1C);
    send(8'h1C, 1'b0, 1'b1, 11);
    expect_ev("good_1c");
    last = 8'h1C;
    quiet("good_1c");

`ifdef PS2_PARITY_CHECK_EN
    push(K_ERR, last);
`else
    push(K_WR, 8'h5A);
`endif
    send(8'h5A, 1'b0, 1'b1, 11);
    expect_ev("parity");
`ifndef PS2_PARITY_CHECK_EN
    last = 8'h5A;
`endif
    quiet("parity");

    bus.buf_full = 1'b1;
    push(K_OVR, last);
    send(8'h1C, 1'b0, 1'b1, 11);
    expect_ev("overrun");
    bus.buf_full = 1'b0;
    quiet("overrun");
    push(K_WR, 8'h5A);
    send(8'h5A, 1'b1, 1'b1, 11);
    expect_ev("after_full");
    last = 8'h5A;
    quiet("after_full");

    push(K_ERR, last);
    send(8'h5A, 1'b1, 1'b1, 5);
    repeat (300) @(negedge clk);
    expect_ev("timeout");
    quiet("timeout");
    push(K_WR, 8'h5A);
    send(8'h5A, 1'b1, 1'b1, 11);
    expect_ev("post_timeout");
    quiet("post_timeout");

    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    chk("glitch_busy_mid", 32'(bus.rx_busy), 32'd0);
    quiet("glitch");

    push(K_ERR, last);
    send(8'h1C, 1'b0, 1'b0, 11);
    expect_ev("bad_stop");
    quiet("bad_stop");

    send(8'h1C, 1'b0, 1'b1, 6);
    chk("pre_rst_busy", 32'(bus.rx_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_data", 32'(bus.rx_data), 32'h00);
    chk("mid_rst_wr", 32'(bus.wr_en), 32'd0);
    chk("mid_rst_err", 32'(bus.frame_err), 32'd0);
    quiet("mid_rst");
    push(K_WR, 8'h1C);
    send(8'h1C, 1'b0, 1'b1, 11);
    expect_ev("post_rst");
    quiet("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
